// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//
// Receive-side safety and sequence monitor for the traffic light controller's lamp outputs.
// Each clock it samples the four lamp vectors, decodes them into a phase number (1-6, 0 for
// no legal phase), and checks lamp encoding, conflicting greens, phase order and, optionally,
// per-phase dwell time.
//
// Optional feature macro: TLM_TIMING_CHECK_EN
//   defined     -> understay/overstay checks active (err_flags[4:3])
//   not defined -> dwell comparators omitted, err_flags[4:3] stay 0
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset
//   light_M1   in   3  lamp vector, 001 green / 010 yellow / 100 red
//   light_M2   in   3  lamp vector
//   light_MT   in   3  lamp vector
//   light_S    in   3  lamp vector
//   clr_err    in   1  clears err_flags and err_cnt
//   phase      out  3  decoded phase of previous sample (0 = none)
//   locked     out  1  monitor is tracking the sequence
//   err_flags  out  5  sticky: [0] encoding [1] conflict [2] sequence [3] understay [4] overstay
//   err_pulse  out  1  one cycle per erroring sample
//   err_cnt    out  8  erroring samples, saturates at 255
//   cycle_cnt  out 16  completed P1..P6->P1 cycles, wraps

module traffic_light_monitor #(
  parameter int unsigned DWELL_P1 = 8,
  parameter int unsigned DWELL_P2 = 3,
  parameter int unsigned DWELL_P3 = 6,
  parameter int unsigned DWELL_P4 = 4,
  parameter int unsigned DWELL_P5 = 4,
  parameter int unsigned DWELL_P6 = 3,
  parameter int unsigned CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  light_M1,
  input  logic [2:0]  light_M2,
  input  logic [2:0]  light_MT,
  input  logic [2:0]  light_S,
  input  logic        clr_err,
  output logic [2:0]  phase,
  output logic        locked,
  output logic [4:0]  err_flags,
  output logic        err_pulse,
  output logic [7:0]  err_cnt,
  output logic [15:0] cycle_cnt
);

  localparam logic [2:0] LampG = 3'b001;
  localparam logic [2:0] LampY = 3'b010;
  localparam logic [2:0] LampR = 3'b100;

  localparam logic [CNT_W-1:0] DwellMax = '1;
  localparam logic [CNT_W-1:0] DwellOne = CNT_W'(1);

  typedef enum logic [0:0] {StSync, StTrack} state_e;

  state_e           state_q, state_d;
  logic [2:0]       prev_phase_q;
  logic [CNT_W-1:0] dwell_q, dwell_d;

  logic [2:0] cur_phase;
  logic [2:0] succ_phase;
  logic       enc_err, conf_err, seq_err, under_err, over_err;
  logic       cyc_inc;
  logic [4:0] err_new;
  logic       err_any;

  function automatic logic is_one_hot(logic [2:0] v);
    return (v == LampG) || (v == LampY) || (v == LampR);
  endfunction

`ifdef TLM_TIMING_CHECK_EN
  function automatic logic [CNT_W-1:0] dwell_req(logic [2:0] p);
    case (p)
      3'd1:    return CNT_W'(DWELL_P1);
      3'd2:    return CNT_W'(DWELL_P2);
      3'd3:    return CNT_W'(DWELL_P3);
      3'd4:    return CNT_W'(DWELL_P4);
      3'd5:    return CNT_W'(DWELL_P5);
      3'd6:    return CNT_W'(DWELL_P6);
      default: return '0;
    endcase
  endfunction
`endif

  // Exact-match decode of all four vectors.
  always_comb begin
    cur_phase = 3'd0;
    case ({light_M1, light_M2, light_MT, light_S})
      {LampG, LampG, LampR, LampR}: cur_phase = 3'd1;
      {LampG, LampY, LampR, LampR}: cur_phase = 3'd2;
      {LampG, LampR, LampG, LampR}: cur_phase = 3'd3;
      {LampY, LampR, LampY, LampR}: cur_phase = 3'd4;
      {LampR, LampR, LampR, LampG}: cur_phase = 3'd5;
      {LampR, LampR, LampR, LampY}: cur_phase = 3'd6;
      default:                      cur_phase = 3'd0;
    endcase
  end

  // Encoding and conflict checks are independent of decode and FSM state.
  always_comb begin
    enc_err  = !is_one_hot(light_M1) || !is_one_hot(light_M2) ||
               !is_one_hot(light_MT) || !is_one_hot(light_S);
    conf_err = ((light_S != LampR) &&
                ((light_M1 != LampR) || (light_M2 != LampR) || (light_MT != LampR))) ||
               ((light_MT != LampR) && (light_M2 != LampR));
  end

  assign succ_phase = (prev_phase_q == 3'd6) ? 3'd1 : prev_phase_q + 3'd1;

  // In TRACK, prev_phase_q always holds the phase being tracked.
  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    seq_err   = 1'b0;
    under_err = 1'b0;
    over_err  = 1'b0;
    cyc_inc   = 1'b0;
    unique case (state_q)
      StSync: begin
        if ((cur_phase == 3'd1) && (prev_phase_q != 3'd1)) begin
          state_d = StTrack;
          dwell_d = DwellOne;
        end else begin
          dwell_d = '0;
        end
      end
      StTrack: begin
        if (cur_phase == prev_phase_q) begin
          if (dwell_q != DwellMax) begin
            dwell_d = dwell_q + DwellOne;
          end
`ifdef TLM_TIMING_CHECK_EN
          // Fires only on the step from DWELL_Pn to DWELL_Pn+1.
          over_err = (dwell_q == dwell_req(prev_phase_q)) && (dwell_q != DwellMax);
`endif
        end else if (cur_phase == succ_phase) begin
          dwell_d = DwellOne;
          cyc_inc = (prev_phase_q == 3'd6);
`ifdef TLM_TIMING_CHECK_EN
          under_err = (dwell_q < dwell_req(prev_phase_q));
`endif
        end else begin
          seq_err = 1'b1;
          state_d = StSync;
          dwell_d = '0;
        end
      end
      default: begin
        state_d = StSync;
        dwell_d = '0;
      end
    endcase
  end

  assign err_new = {over_err, under_err, seq_err, conf_err, enc_err};
  assign err_any = |err_new;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StSync;
      prev_phase_q <= 3'd0;
      dwell_q      <= '0;
      phase        <= 3'd0;
      locked       <= 1'b0;
      err_flags    <= 5'd0;
      err_pulse    <= 1'b0;
      err_cnt      <= 8'd0;
      cycle_cnt    <= 16'd0;
    end else begin
      state_q      <= state_d;
      prev_phase_q <= cur_phase;
      dwell_q      <= dwell_d;
      phase        <= cur_phase;
      locked       <= (state_d == StTrack);
      err_pulse    <= err_any;
      // A clear in the same cycle as a new error keeps only the new error.
      err_flags    <= clr_err ? err_new : (err_flags | err_new);
      if (err_any) begin
        if (clr_err) begin
          err_cnt <= 8'd1;
        end else if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end else if (clr_err) begin
        err_cnt <= 8'd0;
      end
      if (cyc_inc) begin
        cycle_cnt <= cycle_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

`ifdef TLM_TIMING_CHECK_EN
  localparam logic Timing = 1'b1;
`else
  localparam logic Timing = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  phase;
    logic        locked;
    logic [4:0]  flags;
    logic        pulse;
    logic [7:0]  cnt;
    logic [15:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_err = 1'b0;
  logic [2:0]  m1 = R, m2 = R, mt = R, s = R;
  logic [2:0]  phase;
  logic        locked;
  logic [4:0]  err_flags;
  logic        err_pulse;
  logic [7:0]  err_cnt;
  logic [15:0] cycle_cnt;

  int   total = 0;
  int   passed = 0;
  exp_t sb[$];

  logic [4:0]  e_flags = '0;
  logic [7:0]  e_cnt = '0;
  logic [15:0] e_cyc = '0;
  int          last_p = 0;
  int          dw[7] = '{0, 8, 3, 6, 4, 4, 3};

  always #5 clk = ~clk;

  traffic_light_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .light_M1  (m1),
    .light_M2  (m2),
    .light_MT  (mt),
    .light_S   (s),
    .clr_err   (clr_err),
    .phase     (phase),
    .locked    (locked),
    .err_flags (err_flags),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .cycle_cnt (cycle_cnt)
  );

  function automatic logic [11:0] lamps(int p);
    case (p)
      1:       return {G, G, R, R};
      2:       return {G, Y, R, R};
      3:       return {G, R, G, R};
      4:       return {Y, R, Y, R};
      5:       return {R, R, R, G};
      6:       return {R, R, R, Y};
      default: return {R, R, R, R};
    endcase
  endfunction

  function automatic exp_t mk(logic [2:0] ph, logic lk, logic pulse);
    exp_t e;
    e.phase  = ph;
    e.locked = lk;
    e.flags  = e_flags;
    e.pulse  = pulse;
    e.cnt    = e_cnt;
    e.cyc    = e_cyc;
    return e;
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Drive one sample, queue its expectation, then compare once the registered result appears.
  task automatic step(logic [11:0] l, logic clr, logic r, exp_t e);
    exp_t x;
    {m1, m2, mt, s} = l;
    clr_err = clr;
    rst     = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("phase",     {13'd0, phase},     {13'd0, x.phase});
    chk("locked",    {15'd0, locked},    {15'd0, x.locked});
    chk("err_flags", {11'd0, err_flags}, {11'd0, x.flags});
    chk("err_pulse", {15'd0, err_pulse}, {15'd0, x.pulse});
    chk("err_cnt",   {8'd0, err_cnt},    {8'd0, x.cnt});
    chk("cycle_cnt", cycle_cnt,          x.cyc);
  endtask

  // Legal, locked run of n samples of phase p.
  task automatic run(int p, int n);
    for (int i = 0; i < n; i++) begin
      if (i == 0 && p == 1 && last_p == 6) e_cyc++;
      step(lamps(p), 1'b0, 1'b0, mk(3'(p), 1'b1, 1'b0));
      last_p = p;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    step(lamps(0), 1'b0, 1'b1, mk(3'd0, 1'b0, 1'b0));
    step(lamps(0), 1'b0, 1'b1, mk(3'd0, 1'b0, 1'b0));
    step(lamps(0), 1'b0, 1'b0, mk(3'd0, 1'b0, 1'b0));
    last_p = 0;

    // Nominal: two full cycles then P1
    for (int c = 0; c < 2; c++) begin
      for (int p = 1; p <= 6; p++) run(p, dw[p]);
    end
    run(1, 1);

    // Phase skip P2 -> P4
    run(1, 7);
    run(2, 3);
    e_flags |= 5'b00100;
    e_cnt++;
    step(lamps(4), 1'b0, 1'b0, mk(3'd4, 1'b0, 1'b1));
    step(lamps(4), 1'b0, 1'b0, mk(3'd4, 1'b0, 1'b0));
    step(lamps(5), 1'b0, 1'b0, mk(3'd5, 1'b0, 1'b0));
    last_p = 5;
    run(1, 1);

    // Clear while locked
    e_flags = '0;
    e_cnt   = '0;
    step(lamps(1), 1'b1, 1'b0, mk(3'd1, 1'b1, 1'b0));

    // Overstay: 9th P1 sample
    run(1, 6);
    if (Timing) begin
      e_flags |= 5'b10000;
      e_cnt++;
    end
    step(lamps(1), 1'b0, 1'b0, mk(3'd1, 1'b1, Timing));
    run(1, 1);
    run(2, 3);

    // Conflict while locked: S green with M1 green
    e_flags |= 5'b00110;
    e_cnt++;
    step({G, Y, R, G}, 1'b0, 1'b0, mk(3'd0, 1'b0, 1'b1));
    step(lamps(0), 1'b0, 1'b0, mk(3'd0, 1'b0, 1'b0));
    last_p = 0;

    // Bad encoding, clear, clear with simultaneous new error
    e_flags |= 5'b00001;
    e_cnt++;
    step({R, 3'b011, R, R}, 1'b0, 1'b0, mk(3'd0, 1'b0, 1'b1));
    e_flags = '0;
    e_cnt   = '0;
    step(lamps(0), 1'b1, 1'b0, mk(3'd0, 1'b0, 1'b0));
    e_flags = 5'b00001;
    e_cnt   = 8'd1;
    step({R, 3'b011, R, R}, 1'b1, 1'b0, mk(3'd0, 1'b0, 1'b1));
    step(lamps(0), 1'b0, 1'b0, mk(3'd0, 1'b0, 1'b0));

    // Reset mid-P3, then re-lock on the first P1
    run(1, 8);
    run(2, 3);
    run(3, 2);
    e_flags = '0;
    e_cnt   = '0;
    e_cyc   = '0;
    step(lamps(3), 1'b0, 1'b1, mk(3'd0, 1'b0, 1'b0));
    last_p = 0;
    run(1, 2);
    run(2, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
